// File: rtl/alu_seq_pkg.sv
// Shared definitions for the double-width ALU sequencer and its ALU.
//   state_t        : sequencer FSM states
//   SEL_*          : select field positions and named select codes
//   FLAG_*         : bit positions inside the {z,n,c,v} flag word
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SEL_LOGIC_BIT = 3;
  localparam int SEL_CIN_BIT   = 0;

  // Arithmetic codes carry cin in bit 0; SUB is A + ~B + 1.
  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0011;
  localparam logic [3:0] SEL_AND = 4'b1000;
  localparam logic [3:0] SEL_OR  = 4'b1010;
  localparam logic [3:0] SEL_XOR = 4'b1100;
  localparam logic [3:0] SEL_NOT = 4'b1110;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/myALU.sv
// BW-wide combinational ALU shared by the sequencer.
// Ports:
//   a, b  in  BW : operands
//   sel   in  4  : {s2,s1,s0,cin}; s2=1 logic op, s2=0 arithmetic op
//   aout  out BW : result
//   cpsw  out 4  : {z,n,cout,ov}
// Arithmetic ops ({s1,s0}): 00 A+B+cin, 01 A+~B+cin, 10 A+cin, 11 A+all-ones+cin.
// Logic ops ({s1,s0}):      00 AND, 01 OR, 10 XOR, 11 NOT A. cout/ov are 0.
module myALU
  import alu_seq_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [3:0]    sel,
  output logic [BW-1:0] aout,
  output logic [3:0]    cpsw
);

  logic [BW-1:0] bop;
  logic [BW:0]   sum;

  always_comb begin
    bop  = '0;
    sum  = '0;
    aout = '0;
    cpsw = '0;
    if (sel[SEL_LOGIC_BIT]) begin
      case (sel[2:1])
        2'b00:   aout = a & b;
        2'b01:   aout = a | b;
        2'b10:   aout = a ^ b;
        default: aout = ~a;
      endcase
    end else begin
      case (sel[2:1])
        2'b00:   bop = b;
        2'b01:   bop = ~b;
        2'b10:   bop = '0;
        default: bop = '1;
      endcase
      sum  = {1'b0, a} + {1'b0, bop} + {{BW{1'b0}}, sel[SEL_CIN_BIT]};
      aout = sum[BW-1:0];
      cpsw[FLAG_C] = sum[BW];
      // signed overflow: operands agree in sign, result disagrees
      cpsw[FLAG_V] = (a[BW-1] == bop[BW-1]) && (aout[BW-1] != a[BW-1]);
    end
    cpsw[FLAG_Z] = (aout == '0);
    cpsw[FLAG_N] = aout[BW-1];
  end

endmodule

// File: rtl/alu_dw_seq.sv
// Double-width operation sequencer for a shared BW-wide ALU.
// Runs a low pass and, for double width, a high pass with the low-pass
// carry chained into the ALU carry-in.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_sel, cmd_dw       : ALU select {s2,s1,s0,cin}, double-width enable
//   cmd_a, cmd_b          : 2*BW operands
//   alu_a, alu_b, alu_sel : ALU drive (zero when no pass is running)
//   alu_aout, alu_cpsw    : ALU result and {z,n,cout,ov}
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data, rsp_flags   : 2*BW result and {z,n,c,v}
//
// state | meaning
// IDLE  | ready for a command
// LO    | low-half pass on the ALU
// HI    | high-half pass, carry-in from low pass for arithmetic ops
// DONE  | response held until consumed
module alu_dw_seq
  import alu_seq_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_sel,
  input  logic            cmd_dw,
  input  logic [2*BW-1:0] cmd_a,
  input  logic [2*BW-1:0] cmd_b,
  output logic [BW-1:0]   alu_a,
  output logic [BW-1:0]   alu_b,
  output logic [3:0]      alu_sel,
  input  logic [BW-1:0]   alu_aout,
  input  logic [3:0]      alu_cpsw,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*BW-1:0] rsp_data,
  output logic [3:0]      rsp_flags
);

  state_t            state, state_nxt;
  logic [3:0]        sel_q;
  logic              dw_q;
  logic [2*BW-1:0]   a_q, b_q;
  logic [BW-1:0]     res_lo;
  logic              c_lo, z_lo;
  logic [2*BW-1:0]   data_q;
  logic [3:0]        flags_q;
  logic [3:0]        flags_hi;

  // Double-width zero needs both halves zero; n, c, v belong to the top half.
  always_comb begin
    flags_hi         = alu_cpsw;
    flags_hi[FLAG_Z] = z_lo & alu_cpsw[FLAG_Z];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      dw_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_lo  <= '0;
      c_lo    <= 1'b0;
      z_lo    <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sel_q <= cmd_sel;
            dw_q  <= cmd_dw;
            a_q   <= cmd_a;
            b_q   <= cmd_b;
          end
        end
        LO: begin
          res_lo <= alu_aout;
          c_lo   <= alu_cpsw[FLAG_C];
          z_lo   <= alu_cpsw[FLAG_Z];
          if (!dw_q) begin
            data_q  <= {{BW{1'b0}}, alu_aout};
            flags_q <= alu_cpsw;
          end
        end
        HI: begin
          data_q  <= {alu_aout, res_lo};
          flags_q <= flags_hi;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = '0;
    case (state)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) state_nxt = LO;
      end
      LO: begin
        alu_a     = a_q[BW-1:0];
        alu_b     = b_q[BW-1:0];
        alu_sel   = sel_q;
        state_nxt = dw_q ? HI : DONE;
      end
      HI: begin
        alu_a     = a_q[2*BW-1:BW];
        alu_b     = b_q[2*BW-1:BW];
        // logic ops have no carry chain, so their select passes through intact
        alu_sel   = sel_q[SEL_LOGIC_BIT] ? sel_q : {sel_q[3:1], c_lo};
        state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_data  = data_q;
  assign rsp_flags = flags_q;

endmodule
